// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready inter-stage pipeline register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and break the in_ready <- out_ready path.
module pipe_stage_reg #(
   parameter int PAYLOAD_W   = 32,
   parameter int CNT_W       = 16,
   parameter int ZERO_BUBBLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [PAYLOAD_W-1:0] DATA_ZERO = {PAYLOAD_W{1'b0}};
   localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

   logic                 out_valid_r;
   logic                 out_valid_s;
   logic [PAYLOAD_W-1:0] out_data_r;
   logic [PAYLOAD_W-1:0] out_data_s;
   logic [CNT_W-1:0]     stall_cnt_r;
   logic [CNT_W-1:0]     stall_cnt_s;
   logic [PAYLOAD_W-1:0] bubble_data_s;
   logic                 in_xfer_s;

   // Payload value left in the main register whenever it goes empty
   always_comb begin
      if (ZERO_BUBBLE != 0) begin
         bubble_data_s = DATA_ZERO;
      end else begin
         bubble_data_s = out_data_r;
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   logic                 skid_valid_r;
   logic                 skid_valid_s;
   logic [PAYLOAD_W-1:0] skid_data_r;
   logic [PAYLOAD_W-1:0] skid_data_s;
   logic                 in_ready_r;
   logic                 in_ready_s;
   logic                 out_xfer_s;

   assign in_xfer_s  = in_valid & in_ready_r;
   assign out_xfer_s = out_valid_r & out_ready;

   // Next state of the main/skid pair; skid is only ever occupied while main is full
   always_comb begin
      out_valid_s  = out_valid_r;
      out_data_s   = out_data_r;
      skid_valid_s = skid_valid_r;
      skid_data_s  = skid_data_r;
      if (flush) begin
         out_valid_s  = 1'b0;
         out_data_s   = bubble_data_s;
         skid_valid_s = 1'b0;
      end else if (!out_valid_r) begin
         out_valid_s = in_xfer_s;
         if (in_xfer_s) begin
            out_data_s = in_data;
         end else begin
            out_data_s = bubble_data_s;
         end
      end else if (out_xfer_s) begin
         if (skid_valid_r) begin
            out_data_s   = skid_data_r;
            skid_valid_s = 1'b0;
         end else if (in_xfer_s) begin
            out_data_s = in_data;
         end else begin
            out_valid_s = 1'b0;
            out_data_s  = bubble_data_s;
         end
      end else if (in_xfer_s) begin
         skid_valid_s = 1'b1;
         skid_data_s  = in_data;
      end else begin
         skid_valid_s = skid_valid_r;
      end
      in_ready_s = ~skid_valid_s;
   end

   // Skid register and registered in_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_r <= 1'b0;
         skid_data_r  <= DATA_ZERO;
         in_ready_r   <= 1'b1;
      end else begin
         skid_valid_r <= skid_valid_s;
         skid_data_r  <= skid_data_s;
         in_ready_r   <= in_ready_s;
      end
   end

   assign in_ready = in_ready_r;
`else
   logic in_ready_s;

   // An empty stage always accepts; a full one only when it is being drained
   assign in_ready_s = ~out_valid_r | out_ready;
   assign in_xfer_s  = in_valid & in_ready_s;

   // Next state of the single main entry
   always_comb begin
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      if (flush) begin
         out_valid_s = 1'b0;
         out_data_s  = bubble_data_s;
      end else if (in_ready_s) begin
         out_valid_s = in_valid;
         if (in_xfer_s) begin
            out_data_s = in_data;
         end else begin
            out_data_s = bubble_data_s;
         end
      end else begin
         out_valid_s = out_valid_r;
      end
   end

   assign in_ready = in_ready_s;
`endif

   // Saturating back-pressure counter; clear takes precedence over counting
   always_comb begin
      if (cnt_clr) begin
         stall_cnt_s = CNT_ZERO;
      end else if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_s = stall_cnt_r + CNT_W'(1'b1);
      end else begin
         stall_cnt_s = stall_cnt_r;
      end
   end

   // Main output register and stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= DATA_ZERO;
         stall_cnt_r <= CNT_ZERO;
      end else begin
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         stall_cnt_r <= stall_cnt_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + randomized bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;

   localparam int PW = 32;
   localparam int CW = 3;
   localparam int ZB = 1;
`ifdef PIPE_STAGE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int CNT_LIMIT = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_data;
   logic          cnt_clr;
   logic [CW-1:0] stall_cnt;

   pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(CW), .ZERO_BUBBLE(ZB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: FIFO of held payloads, visible out_data, stall count
   logic [PW-1:0] q[$];
   logic [PW-1:0] m_data;
   int            m_cnt;
   int            vectors;
   int            miscompares;
   bit            acc;

   function automatic bit m_in_ready();
      if (DEPTH == 2) return q.size() < 2;
      return (q.size() == 0) || (out_ready == 1'b1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("in_ready",  32'(in_ready),  32'(m_in_ready()));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
   endtask

   task automatic model_reset();
      q.delete();
      m_data = '0;
      m_cnt  = 0;
   endtask

   // Compare at the falling edge, then advance the model across the rising edge
   task automatic cycle();
      bit in_x;
      bit out_x;
      @(negedge clk);
      check_all();
      in_x  = in_valid && m_in_ready();
      out_x = (q.size() > 0) && out_ready;
      if (cnt_clr) m_cnt = 0;
      else if ((q.size() > 0) && !out_ready && (m_cnt < CNT_LIMIT)) m_cnt++;
      if (flush) begin
         q.delete();
      end else begin
         if (out_x) void'(q.pop_front());
         if (in_x) q.push_back(in_data);
      end
      if (q.size() > 0) m_data = q[0];
      else if (ZB != 0) m_data = '0;
      acc = in_x;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_check(input string pfx);
      chk({pfx, "_valid"}, 32'(out_valid), 32'h0);
      chk({pfx, "_data"},  32'(out_data),  32'h0);
      chk({pfx, "_cnt"},   32'(stall_cnt), 32'h0);
      chk({pfx, "_ready"}, 32'(in_ready),  32'h1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      acc         = 1'b0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      cnt_clr     = 1'b0;
      model_reset();
      #2;
      rst_check("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Streaming 1..8 at full throughput
      for (int i = 1; i <= 8; i++) begin
         in_valid  = 1'b1;
         in_data   = PW'(i);
         out_ready = 1'b1;
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      cycle();

      // Back-pressure: 0xA5 held for 5 stall cycles while 0xB6 is offered
      in_valid  = 1'b1;
      in_data   = 32'h0000_00A5;
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      cycle();
      cnt_clr   = 1'b0;
      out_ready = 1'b0;
      in_data   = 32'h0000_00B6;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (acc) in_valid = 1'b0;
      end
      chk("bp_data",  32'(out_data),  32'h0000_00A5);
      chk("bp_cnt",   32'(stall_cnt), 32'h5);
      chk("bp_ready", 32'(in_ready),  32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (acc) in_valid = 1'b0;
      end

      // Flush of a full stage discards the same-cycle 0x77
      in_valid  = 1'b1;
      in_data   = 32'h0000_0033;
      out_ready = 1'b0;
      cycle();
      flush     = 1'b1;
      in_data   = 32'h0000_0077;
      out_ready = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'h0);
      chk("fl_data",  32'(out_data),  32'h0);
      for (int i = 0; i < 3; i++) cycle();

      // Counter saturation, then clear during a stall
      in_valid  = 1'b1;
      in_data   = 32'h0000_0044;
      cnt_clr   = 1'b1;
      cycle();
      in_valid  = 1'b0;
      cnt_clr   = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      chk("sat_cnt", 32'(stall_cnt), 32'h7);
      cnt_clr = 1'b1;
      cycle();
      chk("clr_cnt", 32'(stall_cnt), 32'h0);
      cnt_clr   = 1'b0;
      out_ready = 1'b1;
      cycle();
      cycle();

      // Bubble between 0x11 and 0x22
      in_valid = 1'b1;
      in_data  = 32'h0000_0011;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("bub_valid", 32'(out_valid), 32'h0);
      chk("bub_data",  32'(out_data),  32'h0);
      in_valid = 1'b1;
      in_data  = 32'h0000_0022;
      cycle();
      chk("bub_next", 32'(out_data), 32'h0000_0022);
      in_valid = 1'b0;
      cycle();

      // Asynchronous reset while holding data, no clock edge
      in_valid  = 1'b1;
      in_data   = 32'h0000_005A;
      out_ready = 1'b0;
      cycle();
      rst_n = 1'b0;
      #2;
      rst_check("mid");
      model_reset();
      in_valid = 1'b0;
      #1;
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         cnt_clr   = ($urandom_range(0, 15) == 0);
         cycle();
      end
      flush     = 1'b0;
      cnt_clr   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
